// File: rtl/jtglfgreat_adc_if.sv
// rtl/jtglfgreat_adc_if.sv - CPU-side control/status bus for the Golfing Greed serial ADC
//
// Signals:
//   cpu_cen    CPU clock enable, qualifies every state update in the converter
//   cs, we     control register select and write strobe
//   din[3:0]   control bits: [1:0] channel, [2] start, [3] shift clock
//   adc        serial data / status bit returned to the cabinet input port
//   busy       high while a conversion is running
// Modports: master = CPU / cabinet decoder side, slave = converter side.

interface jtglfgreat_adc_if;
    logic       cpu_cen;
    logic       cs;
    logic       we;
    logic [3:0] din;
    logic       adc;
    logic       busy;

    modport master (
        output cpu_cen,
        output cs,
        output we,
        output din,
        input  adc,
        input  busy
    );

    modport slave (
        input  cpu_cen,
        input  cs,
        input  we,
        input  din,
        output adc,
        output busy
    );
endinterface

// File: rtl/jtglfgreat_adc.sv
// rtl/jtglfgreat_adc.sv - serial 4-channel 8-bit ADC model feeding the cabinet adc status bit
//
// Parameters:
//   CONV_LEN   conversion time in cpu_cen ticks (1..255)
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset, honoured on every clock edge
//   bus        jtglfgreat_adc_if.slave: cpu_cen, cs, we, din[3:0] in; adc, busy out
//   ana0..ana3 unsigned 8-bit analog channel values
// Build option:
//   JTGLFGREAT_ADC_TRACK_EN  defined: the selected channel is sampled when the
//                            conversion ends; undefined: the channel value is
//                            frozen in a hold register on the start edge.

module jtglfgreat_adc #(
    parameter int CONV_LEN = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    jtglfgreat_adc_if.slave    bus,
    input  logic [7:0]         ana0,
    input  logic [7:0]         ana1,
    input  logic [7:0]         ana2,
    input  logic [7:0]         ana3
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [7:0] CNT_INIT = 8'(CONV_LEN - 1);

    state_t     state;
    logic       start_l;
    logic       sclk_l;
    logic [7:0] sr;
    logic [7:0] cnt;
    logic [3:0] bits;
    logic [7:0] sample;
    logic       adc_r;
    logic       busy_r;

    logic       wr;
    logic       start_edge;
    logic       shift_edge;

    function automatic logic [7:0] pick(input logic [1:0] c);
        case (c)
            2'd0:    pick = ana0;
            2'd1:    pick = ana1;
            2'd2:    pick = ana2;
            default: pick = ana3;
        endcase
    endfunction

    assign wr         = bus.cs & bus.we & bus.cpu_cen;
    assign start_edge = wr & bus.din[2] & ~start_l;
    assign shift_edge = wr & bus.din[3] & ~sclk_l;

`ifdef JTGLFGREAT_ADC_TRACK_EN
    // Tracking converter: the channel number is kept and the live input is
    // read at the end of the conversion.
    logic [1:0] ch;
    assign sample = pick(ch);
`else
    // Non-tracking converter: the channel value itself is what must survive
    // the conversion, so the held byte replaces the channel number.
    logic [7:0] hold;
    assign sample = hold;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_l <= 1'b0;
            sclk_l  <= 1'b0;
            sr      <= 8'hFF;
            cnt     <= 8'd0;
            bits    <= 4'd0;
            adc_r   <= 1'b1;
            busy_r  <= 1'b0;
`ifdef JTGLFGREAT_ADC_TRACK_EN
            ch      <= 2'd0;
`else
            hold    <= 8'd0;
`endif
        end else if (bus.cpu_cen) begin
            if (wr) begin
                start_l <= bus.din[2];
                sclk_l  <= bus.din[3];
            end
            // A start edge restarts from any state and swallows a shift edge
            // carried by the same write.
            if (start_edge) begin
`ifdef JTGLFGREAT_ADC_TRACK_EN
                ch     <= bus.din[1:0];
`else
                hold   <= pick(bus.din[1:0]);
`endif
                cnt    <= CNT_INIT;
                state  <= CONV;
                busy_r <= 1'b1;
                adc_r  <= 1'b0;
            end else begin
                case (state)
                    CONV: begin
                        // Compare before decrementing so cnt never wraps.
                        if (cnt == 8'd0) begin
                            sr     <= sample;
                            bits   <= 4'd8;
                            state  <= SHIFT;
                            busy_r <= 1'b0;
                            adc_r  <= sample[7];
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    SHIFT: begin
                        if (shift_edge) begin
                            sr   <= {sr[6:0], 1'b1};
                            bits <= bits - 4'd1;
                            if (bits == 4'd1) begin
                                state <= IDLE;
                                adc_r <= 1'b1;
                            end else begin
                                adc_r <= sr[6];
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.adc  = adc_r;
    assign bus.busy = busy_r;

endmodule

// File: tb/tb_jtglfgreat_adc.sv
// tb/tb_jtglfgreat_adc.sv - self-checking bench for jtglfgreat_adc

module tb_jtglfgreat_adc;

    localparam int CONV_LEN = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ana [4];

    int n_tests = 0;
    int n_fail  = 0;

    jtglfgreat_adc_if bus_if ();

    jtglfgreat_adc #(.CONV_LEN(CONV_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .ana0  (ana[0]),
        .ana1  (ana[1]),
        .ana2  (ana[2]),
        .ana3  (ana[3])
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Idle clocks with cpu_cen low and junk on the bus: never a write.
    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
            bus_if.cpu_cen = 1'b0;
            bus_if.cs      = 1'($urandom);
            bus_if.we      = 1'($urandom);
            bus_if.din     = 4'($urandom);
            cyc();
        end
        bus_if.cs = 1'b0;
        bus_if.we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] d);
        gap();
        bus_if.cpu_cen = 1'b1;
        bus_if.cs      = 1'b1;
        bus_if.we      = 1'b1;
        bus_if.din     = d;
        cyc();
        bus_if.cpu_cen = 1'b0;
        bus_if.cs      = 1'b0;
        bus_if.we      = 1'b0;
    endtask

    // cpu_cen tick without a write (cs high but we low on some ticks).
    task automatic tick();
        gap();
        bus_if.cpu_cen = 1'b1;
        bus_if.cs      = 1'($urandom);
        bus_if.we      = 1'b0;
        bus_if.din     = 4'($urandom);
        cyc();
        bus_if.cpu_cen = 1'b0;
        bus_if.cs      = 1'b0;
    endtask

    // Issue a start write and check that the block is converting afterwards.
    task automatic start_conv(input logic [3:0] word, input string tag);
        wr(word);
        n_tests++;
        if (bus_if.busy !== 1'b1 || bus_if.adc !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_start: busy=%b adc=%b, required busy=1 adc=0", tag, bus_if.busy, bus_if.adc);
        end
    endtask

    // Count cpu_cen ticks until busy drops; the conversion must last CONV_LEN
    // ticks counted from the start write, with adc low throughout.
    task automatic wait_conv(input int pre, input string tag);
        int   ticks;
        logic hold_start;
        bit   bad_adc;
        ticks      = pre;
        hold_start = 1'($urandom);
        bad_adc    = 0;
        // First tick is a write so that the shift-clock level returns low.
        wr({1'b0, hold_start, 2'($urandom)});
        ticks++;
        while (bus_if.busy === 1'b1 && ticks < 4 * CONV_LEN + 10) begin
            if (bus_if.adc !== 1'b0) bad_adc = 1;
            if ($urandom_range(0, 1) == 0) wr({1'b0, hold_start, 2'($urandom)});
            else tick();
            ticks++;
        end
        n_tests++;
        if (ticks != CONV_LEN || bad_adc) begin
            n_fail++;
            $display("FAIL %s_conv_len: ticks=%0d adc_glitch=%0d, required ticks=%0d adc_glitch=0", tag, ticks, bad_adc, CONV_LEN);
        end
    endtask

    // Clock nbits bits out, checking each against the expected byte MSB first.
    task automatic read_bits(input logic [7:0] exp, input int nbits, input string tag);
        logic expbit;
        n_tests++;
        if (bus_if.adc !== exp[7] || bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_msb: adc=%b busy=%b, required adc=%b busy=0", tag, bus_if.adc, bus_if.busy, exp[7]);
        end
        for (int i = 0; i < nbits; i++) begin
            wr(4'b1000);
            expbit = (i < 7) ? ((exp >> (6 - i)) & 8'd1) != 0 : 1'b1;
            n_tests++;
            if (bus_if.adc !== expbit || bus_if.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_bit%0d: adc=%b busy=%b, required adc=%b busy=0", tag, i + 1, bus_if.adc, bus_if.busy, expbit);
            end
            wr(4'b0000);
        end
        if (nbits == 8) begin
            wr(4'b1000);
            wr(4'b0000);
            n_tests++;
            if (bus_if.adc !== 1'b1 || bus_if.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_idle: adc=%b busy=%b, required adc=1 busy=0", tag, bus_if.adc, bus_if.busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus_if.cpu_cen = 1'($urandom);
            bus_if.cs      = 1'b1;
            bus_if.we      = 1'b1;
            bus_if.din     = 4'($urandom);
            cyc();
        end
        bus_if.cpu_cen = 1'b0;
        bus_if.cs      = 1'b0;
        bus_if.we      = 1'b0;
        bus_if.din     = 4'b0000;
        cyc();
        rst_n = 1'b1;
        cyc();
        n_tests++;
        if (bus_if.adc !== 1'b1 || bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: adc=%b busy=%b, required adc=1 busy=0", bus_if.adc, bus_if.busy);
        end
        for (int k = 0; k < 3; k++) begin
            wr(4'b1000);
            n_tests++;
            if (bus_if.adc !== 1'b1 || bus_if.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_shift%0d: adc=%b busy=%b, required adc=1 busy=0", k, bus_if.adc, bus_if.busy);
            end
            wr(4'b0000);
        end
    endtask

    task automatic test_basic_read();
        ana[2] = 8'hA5;
        start_conv(4'b0110, "basic");
        wait_conv(0, "basic");
        read_bits(8'hA5, 8, "basic");
    endtask

    task automatic test_random_reads();
        logic [1:0] c;
        for (int it = 0; it < 6; it++) begin
            for (int j = 0; j < 4; j++) ana[j] = 8'($urandom);
            c = 2'($urandom);
            start_conv({2'b01, c}, $sformatf("rnd%0d", it));
            wait_conv(0, $sformatf("rnd%0d", it));
            read_bits(ana[c], 8, $sformatf("rnd%0d_ch%0d", it, c));
        end
    endtask

    task automatic test_abort();
        ana[0] = 8'h00;
        ana[1] = 8'hFF;
        start_conv(4'b0100, "abort_a");
        wait_conv(0, "abort_a");
        read_bits(8'h00, 3, "abort_a");
        start_conv(4'b0101, "abort_b");
        wait_conv(0, "abort_b");
        read_bits(8'hFF, 8, "abort_b");
        // Abort during CONV: the conversion restarts its full length.
        ana[0] = 8'h3C;
        ana[1] = 8'hC6;
        start_conv(4'b0100, "abort_c");
        for (int k = 0; k < 10; k++) tick();
        wr(4'b0000);
        start_conv(4'b0101, "abort_d");
        wait_conv(0, "abort_d");
        read_bits(8'hC6, 8, "abort_d");
    endtask

    task automatic test_simultaneous();
        ana[0] = 8'($urandom);
        ana[1] = 8'($urandom);
        start_conv(4'b0100, "simul_a");
        wait_conv(0, "simul_a");
        read_bits(ana[0], 2, "simul_a");
        wr(4'b0001);
        start_conv(4'b1101, "simul_b");
        wait_conv(0, "simul_b");
        read_bits(ana[1], 8, "simul_b");
    endtask

    task automatic test_config();
        logic [7:0] exp;
        ana[3] = 8'h10;
        start_conv(4'b0111, "config");
        for (int k = 0; k < 10; k++) tick();
        ana[3] = 8'h20;
        wait_conv(10, "config");
`ifdef JTGLFGREAT_ADC_TRACK_EN
        exp = 8'h20;
`else
        exp = 8'h10;
`endif
        read_bits(exp, 8, "config");
    endtask

    task automatic test_reset_mid();
        start_conv(4'b0110, "rstmid");
        for (int k = 0; k < 5; k++) tick();
        bus_if.cpu_cen = 1'b0;
        rst_n = 1'b0;
        cyc();
        n_tests++;
        if (bus_if.adc !== 1'b1 || bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_state: adc=%b busy=%b, required adc=1 busy=0", bus_if.adc, bus_if.busy);
        end
        rst_n = 1'b1;
        for (int k = 0; k < CONV_LEN + 4; k++) tick();
        n_tests++;
        if (bus_if.adc !== 1'b1 || bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: adc=%b busy=%b, required adc=1 busy=0", bus_if.adc, bus_if.busy);
        end
    endtask

    initial begin
        bus_if.cpu_cen = 1'b0;
        bus_if.cs      = 1'b0;
        bus_if.we      = 1'b0;
        bus_if.din     = 4'b0000;
        for (int j = 0; j < 4; j++) ana[j] = 8'h00;
        test_reset();
        test_basic_read();
        test_random_reads();
        test_abort();
        test_simultaneous();
        test_config();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtglfgreat_adc.md
# jtglfgreat_adc

Serial analog-to-digital converter model for the Golfing Greed cabinet. It is the source end of the `adc` status bit that the cabinet input port exposes to the 68000. The CPU writes a control register to pick one of four 8-bit analog channels and start a conversion. It then clocks the result out one bit at a time and reads each bit back through the cabinet port. The block sits beside the cabinet input decoder, fed by the trackball/analog values from the game top level.

## Interface
Parameters:
- `CONV_LEN`, 64, conversion time in `cpu_cen` ticks (1..255)

Ports:
- `clk` in 1: system clock
- `rst_n` in 1: synchronous, active-low reset
- `cpu_cen` in 1: CPU clock enable; every state update is qualified by it
- `cs` in 1: control register select
- `we` in 1: write strobe; a write happens when `cs & we & cpu_cen`
- `din` in 4: control bits, CPU data bits [3:0]
  - [1:0] channel
  - [2] start
  - [3] shift clock
- `ana0`..`ana3` in 8 each: analog channel values, unsigned
- `adc` out 1: serial data/status bit sent to the cabinet input port
- `busy` out 1: high while converting

## Operation
- Registers:
  - `start_l` and `sclk_l`: last written levels of `din[2]` and `din[3]`, updated on every write
  - `ch`: channel, loaded from `din[1:0]` on a start edge only
  - `sr[7:0]`: shift register
  - `cnt[7:0]`: conversion counter
  - `bits[3:0]`: bits remaining
- Edges: start edge = write with `din[2]=1` and `start_l=0`. Shift edge = write with `din[3]=1` and `sclk_l=0`.
- State IDLE: `adc=1`, `busy=0`. A start edge loads `ch` and `cnt=CONV_LEN-1` and enters CONV. Shift edges are ignored.
- State CONV: `adc=0`, `busy=1`. `cnt` decrements on each `cpu_cen`. When `cnt==0` on a `cpu_cen` tick:
  - load `sr` with the sample (see Configuration)
  - set `bits=8`
  - enter SHIFT
  - Shift edges are ignored in CONV.
- State SHIFT: `busy=0`, `adc=sr[7]` (MSB first). Each shift edge shifts `sr` left with 1 filled in and decrements `bits`. The shift edge that brings `bits` to 0 returns the block to IDLE.
- A start edge in CONV or SHIFT aborts the current operation and restarts CONV with the new channel. No partial data is delivered.
- If a single write carries both a start edge and a shift edge, the start edge wins and the shift edge is discarded.
- Writes without an edge only update `start_l`/`sclk_l`. Holding `din[2]=1` never retriggers a conversion.
- Channel mux: `ch` 0..3 selects `ana0`..`ana3`.

## Timing
- All outputs are registered. On reset:
  - `adc=1`, `busy=0`, state IDLE
  - `start_l=0`, `sclk_l=0`, `ch=0`, `sr=8'hFF`, `cnt=0`, `bits=0`
- Reset takes effect on any clock edge, regardless of `cpu_cen`, and returns the block to IDLE even mid-conversion or mid-shift.
- Start edge write on `cpu_cen` tick N: `busy=1` and `adc=0` are visible from the clock after N.
- SHIFT is entered on the `cpu_cen` tick CONV_LEN ticks after N. `adc` shows the MSB from the following clock.
- A shift edge updates `adc` on the next clock. The CPU sees the new bit on its next read.
- `cnt` is 8 bits wide and never wraps: it is compared to 0 before decrementing.

## Configuration
- Macro: `JTGLFGREAT_ADC_TRACK_EN`.
- Defined: the selected channel is sampled at the end of conversion, on the tick CONV→SHIFT. Changes on `ana*` during CONV are reflected in the result, matching the real converter's tracking behaviour.
- Undefined: the channel value is captured into a hold register on the start edge. That value is loaded into `sr` at the end of conversion, so changes on `ana*` during CONV have no effect.

## Test plan
- Reset check: hold `rst_n=0`, then release. `adc=1`, `busy=0`, and shift writes leave `adc` at 1.
- Basic read:
  - `ana2=8'hA5`, CONV_LEN=64, write `din=4'b0110`
  - `busy` stays high for 64 `cpu_cen` ticks, then `adc=1`
  - 8 shift edges (write 4'b1000, then 4'b0000, repeated) yield 1,0,1,0,0,1,0,1
  - after the 8th edge: IDLE, `adc=1`
- Abort:
  - start on ch0 (`ana0=8'h00`), wait for SHIFT, shift 3 bits
  - start on ch1 (`ana1=8'hFF`): CONV re-entered, `adc=0`
  - after conversion, all 8 bits read 1
- Simultaneous edges: in SHIFT, write `din=4'b1101` from prior `4'b0001`. Restart on ch1 occurs and `bits` is not decremented.
- Config: `ana3` changes 8'h10→8'h20 mid-CONV.
  - with `JTGLFGREAT_ADC_TRACK_EN` defined, the result is 8'h20
  - without it, the result is 8'h10
- Reset mid-conversion: pull `rst_n` low during CONV with `cpu_cen=0`. The next clock gives `busy=0` and `adc=1`.
